regfile_wb_buffer: RTL and testbench

- Writer-side companion of the integer register file: buffers write-back results and drives its single write port.
- Accepts results from the execute/LSU stages through a valid/ready handshake and queues them in order in a small FIFO.
- Retires one queued result per cycle into the register file.
- Provides forwarding lookups so readers see results that are still queued and not yet written.

---
 rtl/regfile_wb_buffer_if.sv | 40 ++++
 rtl/regfile_wb_buffer.sv | 107 ++++++++++
 tb/tb_regfile_wb_buffer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_buffer_if.sv
// Bus bundle for the register-file write-back buffer: producer handshake,
// register-file write port, forwarding queries and occupancy status.
interface regfile_wb_buffer_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              in_valid_i;
   logic              in_ready_o;
   logic [ADDR_W-1:0] in_addr_i;
   logic [DATA_W-1:0] in_data_i;
   logic              wb_stall_i;
   logic              we_o_reg;
   logic [ADDR_W-1:0] waddr_o_reg;
   logic [DATA_W-1:0] wdata_o_reg;
   logic [ADDR_W-1:0] fwd_raddr1_i;
   logic [ADDR_W-1:0] fwd_raddr2_i;
   logic              fwd_hit1_o;
   logic [DATA_W-1:0] fwd_data1_o;
   logic              fwd_hit2_o;
   logic [DATA_W-1:0] fwd_data2_o;
   logic [CNT_W-1:0]  count_o;
   logic              empty_o;

   // Producer / pipeline side
   modport master (
      output in_valid_i, in_addr_i, in_data_i, wb_stall_i, fwd_raddr1_i, fwd_raddr2_i,
      input  in_ready_o, we_o_reg, waddr_o_reg, wdata_o_reg,
             fwd_hit1_o, fwd_data1_o, fwd_hit2_o, fwd_data2_o, count_o, empty_o
   );

   // Buffer side
   modport slave (
      input  in_valid_i, in_addr_i, in_data_i, wb_stall_i, fwd_raddr1_i, fwd_raddr2_i,
      output in_ready_o, we_o_reg, waddr_o_reg, wdata_o_reg,
             fwd_hit1_o, fwd_data1_o, fwd_hit2_o, fwd_data2_o, count_o, empty_o
   );
endinterface

// File: rtl/regfile_wb_buffer.sv
// Write-back buffer in front of the integer register file. Results are
// queued in arrival order, one is retired per unstalled cycle, and readers
// can look up the youngest still-pending value of any register.
module regfile_wb_buffer #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input logic               clk,
   input logic               rst,
   regfile_wb_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic empty;
   logic ready;
   logic push;
   logic pop;

   // Youngest pending value for a query address; address 0 never hits.
   // Entries are scanned oldest to youngest so the last match wins.
   function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] query);
      logic [DATA_W:0]  res;
      logic [PTR_W-1:0] idx;
      res = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if ((query != '0) && (CNT_W'(i) < count_q) && (addr_q[idx] == query)) begin
            res = {1'b1, data_q[idx]};
         end
      end
      return res;
   endfunction

   // Handshake, drain and status outputs; ready is held low while in reset
   // and looks only at occupancy, so a full buffer refuses even while popping.
   always_comb begin
      empty = (count_q == '0);
      ready = rst && (count_q < CNT_W'(DEPTH));
      pop   = !empty && !bus.wb_stall_i;
      push  = bus.in_valid_i && ready && (bus.in_addr_i != '0);

      bus.in_ready_o  = ready;
      bus.empty_o     = empty;
      bus.count_o     = count_q;
      bus.we_o_reg    = pop;
      bus.waddr_o_reg = empty ? '0 : addr_q[head_q];
      bus.wdata_o_reg = empty ? '0 : data_q[head_q];
   end

   // Forwarding lookups for both read ports.
   always_comb begin
      {bus.fwd_hit1_o, bus.fwd_data1_o} = fwd_lookup(bus.fwd_raddr1_i);
      {bus.fwd_hit2_o, bus.fwd_data2_o} = fwd_lookup(bus.fwd_raddr2_i);
   end

   // Next-state: store accepted non-x0 results at the tail, advance head on
   // each retired write, and track occupancy from the push/pop pair.
   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         addr_d[tail_q] = bus.in_addr_i;
         data_d[tail_q] = bus.in_data_i;
         tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // State registers; reset discards every pending entry immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Testbench for regfile_wb_buffer: directed scenarios plus randomized
// traffic, checked against a queue-based model of the pending results.
module tb_regfile_wb_buffer;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic clk;
   logic rst;

   regfile_wb_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

   regfile_wb_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Reference state: results held by the buffer, and writes still owed
   entry_t pend[$];
   entry_t exp_q[$];
   bit     last_accept;
   int     pass_cnt;
   int     total_cnt;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net against a hung run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total_cnt++;
      if (actual === expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One cycle of stimulus: drive inputs, then step past the next rising edge
   task automatic applyStimulus(input bit v, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input bit st,
                                input logic [ADDR_W-1:0] q1, input logic [ADDR_W-1:0] q2);
      bus.in_valid_i   = v;
      bus.in_addr_i    = a;
      bus.in_data_i    = d;
      bus.wb_stall_i   = st;
      bus.fwd_raddr1_i = q1;
      bus.fwd_raddr2_i = q2;
      @(posedge clk);
      #1;
   endtask

   // Model of the youngest pending value for a register (x0 never pending)
   function automatic logic [DATA_W:0] model_fwd(input logic [ADDR_W-1:0] q);
      logic [DATA_W:0] r;
      r = '0;
      if (q != '0) begin
         foreach (pend[i]) begin
            if (pend[i].addr == q) r = {1'b1, pend[i].data};
         end
      end
      return r;
   endfunction

   // Model update on each edge: accept while fewer than DEPTH are held,
   // retire the oldest when unstalled, and drop x0 results.
   always @(posedge clk or negedge rst) begin
      bit     m_acc;
      bit     m_pop;
      entry_t e;
      if (!rst) begin
         pend.delete();
         exp_q.delete();
         last_accept = 1'b0;
      end else begin
         m_acc = bus.in_valid_i && (pend.size() < DEPTH);
         m_pop = (pend.size() > 0) && !bus.wb_stall_i;
         if (m_pop) void'(pend.pop_front());
         if (m_acc && (bus.in_addr_i != '0)) begin
            e.addr = bus.in_addr_i;
            e.data = bus.in_data_i;
            pend.push_back(e);
            exp_q.push_back(e);
         end
         last_accept = m_acc;
      end
   end

   // Monitor: away from the rising edge, compare status and forwarding with
   // the model and pop the scoreboard whenever the DUT presents a write.
   always @(negedge clk) begin
      logic [DATA_W:0] f1;
      logic [DATA_W:0] f2;
      entry_t          e;
      if (rst) begin
         f1 = model_fwd(bus.fwd_raddr1_i);
         f2 = model_fwd(bus.fwd_raddr2_i);
         checkOutput("count_o", 64'(bus.count_o), 64'(pend.size()));
         checkOutput("empty_o", 64'(bus.empty_o), 64'(pend.size() == 0));
         checkOutput("in_ready_o", 64'(bus.in_ready_o), 64'(pend.size() < DEPTH));
         checkOutput("we_o_reg", 64'(bus.we_o_reg), 64'((pend.size() > 0) && !bus.wb_stall_i));
         checkOutput("fwd_hit1_o", 64'(bus.fwd_hit1_o), 64'(f1[DATA_W]));
         checkOutput("fwd_data1_o", bus.fwd_data1_o, f1[DATA_W-1:0]);
         checkOutput("fwd_hit2_o", 64'(bus.fwd_hit2_o), 64'(f2[DATA_W]));
         checkOutput("fwd_data2_o", bus.fwd_data2_o, f2[DATA_W-1:0]);
         if (pend.size() == 0) begin
            checkOutput("idle_waddr", 64'(bus.waddr_o_reg), 64'd0);
            checkOutput("idle_wdata", bus.wdata_o_reg, 64'd0);
         end
         if (bus.we_o_reg) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("[TB] FAIL unexpected_write: got addr %0d with nothing owed", bus.waddr_o_reg);
            end else begin
               e = exp_q.pop_front();
               checkOutput("wb_addr", 64'(bus.waddr_o_reg), 64'(e.addr));
               checkOutput("wb_data", bus.wdata_o_reg, e.data);
            end
         end
      end
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      bit                done;
      pass_cnt  = 0;
      total_cnt = 0;
      rst = 1'b0;
      bus.in_valid_i   = 1'b0;
      bus.in_addr_i    = '0;
      bus.in_data_i    = '0;
      bus.wb_stall_i   = 1'b0;
      bus.fwd_raddr1_i = '0;
      bus.fwd_raddr2_i = '0;
      #1;
      checkOutput("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
      checkOutput("rst_we", 64'(bus.we_o_reg), 64'd0);
      checkOutput("rst_count", 64'(bus.count_o), 64'd0);
      checkOutput("rst_empty", 64'(bus.empty_o), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      $display("[TB] reset released");

      // Single write: accepted on one edge, presented to the file the next cycle
      applyStimulus(1, 5'd5, 64'h1234, 0, 5'd5, 5'd0);
      checkOutput("single_accept", 64'(last_accept), 64'd1);
      checkOutput("single_we", 64'(bus.we_o_reg), 64'd1);
      checkOutput("single_waddr", 64'(bus.waddr_o_reg), 64'd5);
      checkOutput("single_wdata", bus.wdata_o_reg, 64'h1234);
      checkOutput("single_fwd_hit", 64'(bus.fwd_hit1_o), 64'd1);
      applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 5'd0);
      checkOutput("single_empty_after", 64'(bus.empty_o), 64'd1);

      // Fill while stalled, then release and see order and ready recovery
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(1, ADDR_W'(i), 64'(32'hA000 + i), 1, 5'd0, 5'd0);
      end
      checkOutput("full_count", 64'(bus.count_o), 64'(DEPTH));
      checkOutput("full_ready", 64'(bus.in_ready_o), 64'd0);
      applyStimulus(1, 5'd5, 64'hA005, 1, 5'd0, 5'd0);
      checkOutput("full_refuse_stalled", 64'(last_accept), 64'd0);
      applyStimulus(1, 5'd5, 64'hA005, 0, 5'd0, 5'd0);
      checkOutput("full_refuse_draining", 64'(last_accept), 64'd0);
      checkOutput("ready_after_pop", 64'(bus.in_ready_o), 64'd1);
      applyStimulus(1, 5'd5, 64'hA005, 0, 5'd0, 5'd0);
      checkOutput("fifth_accept", 64'(last_accept), 64'd1);
      repeat (DEPTH + 1) applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 5'd0);
      checkOutput("fill_drained", 64'(bus.empty_o), 64'd1);

      // Forwarding picks the youngest of two results for the same register
      applyStimulus(1, 5'd7, 64'hA, 1, 5'd7, 5'd0);
      applyStimulus(1, 5'd7, 64'hB, 1, 5'd7, 5'd0);
      applyStimulus(0, 5'd0, 64'd0, 1, 5'd7, 5'd0);
      checkOutput("fwd_prio_hit1", 64'(bus.fwd_hit1_o), 64'd1);
      checkOutput("fwd_prio_data1", bus.fwd_data1_o, 64'hB);
      checkOutput("fwd_x0_hit2", 64'(bus.fwd_hit2_o), 64'd0);
      checkOutput("fwd_x0_data2", bus.fwd_data2_o, 64'd0);
      applyStimulus(0, 5'd0, 64'd0, 1, 5'd7, 5'd9);
      checkOutput("fwd_miss_hit2", 64'(bus.fwd_hit2_o), 64'd0);
      repeat (3) applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 5'd0);

      // x0 result completes its handshake but is never stored or written
      applyStimulus(1, 5'd0, 64'hFF, 0, 5'd0, 5'd0);
      checkOutput("x0_accept", 64'(last_accept), 64'd1);
      checkOutput("x0_count", 64'(bus.count_o), 64'd0);
      checkOutput("x0_we", 64'(bus.we_o_reg), 64'd0);
      applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 5'd0);

      // Streaming: one accept and one write per cycle at steady occupancy
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1, ADDR_W'(i), 64'(32'hC000 + i), 0, ADDR_W'(i), 5'd0);
         checkOutput("stream_count", 64'(bus.count_o), 64'd1);
         checkOutput("stream_ready", 64'(bus.in_ready_o), 64'd1);
      end
      repeat (2) applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 5'd0);

      // Reset mid-run with three entries queued
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, ADDR_W'(10 + i), 64'(32'hD000 + i), 1, 5'd10, 5'd11);
      end
      bus.in_valid_i = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("midrst_count", 64'(bus.count_o), 64'd0);
      checkOutput("midrst_empty", 64'(bus.empty_o), 64'd1);
      checkOutput("midrst_we", 64'(bus.we_o_reg), 64'd0);
      checkOutput("midrst_ready", 64'(bus.in_ready_o), 64'd0);
      checkOutput("midrst_fwd_hit1", 64'(bus.fwd_hit1_o), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.wb_stall_i = 1'b0;
      #1;
      checkOutput("postrst_ready", 64'(bus.in_ready_o), 64'd1);
      checkOutput("postrst_we", 64'(bus.we_o_reg), 64'd0);
      @(posedge clk);
      #1;
      repeat (2) applyStimulus(0, 5'd0, 64'd0, 0, 5'd10, 5'd11);

      // Randomized traffic; a refused result is held until accepted
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            ra   = ADDR_W'($urandom_range(0, 7));
            rd   = {$urandom, $urandom};
            done = 1'b0;
            for (int t = 0; t < 64 && !done; t++) begin
               applyStimulus(1, ra, rd, ($urandom_range(0, 3) == 0),
                             ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
               done = last_accept;
            end
            if (!done) begin
               total_cnt++;
               $display("[TB] FAIL accept_timeout: got no accept in 64 cycles, required accept");
            end
         end else begin
            applyStimulus(0, ADDR_W'($urandom_range(0, 7)), {$urandom, $urandom},
                          ($urandom_range(0, 3) == 0),
                          ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
         end
      end
      repeat (DEPTH + 2) applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 5'd0);
      checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
